uc_feeder: RTL and testbench
============================

Name: uc_feeder

Overview:
- Hardware replacement for the bench-side unit-clause handler in the BCP accelerator.
- Buffers the initial unit clauses (UCs) of a trace and issues them to the UC arbiter (mem2uca interface) one at a time, on engine stall.
- Drains the model stack (mstack) into a result FIFO for host readout.
- Measures processing cycles from start to conflict or completion.
- Generalises the single-shot bench loop:
  - parametrised depth and width;
  - edge or level issue mode;
  - result backpressure;
  - drain/done detection.

Parameters:
- LIT_W, 8, literal width (matches lit_t).
- UC_DEPTH, 16, initial-UC FIFO entries (power of 2).
- RES_DEPTH, 32, result FIFO entries (power of 2).
- CNT_W, 32, cycle-counter width.
- ISSUE_MODE, 0:
  - 0 = issue on stall rising edge;
  - 1 = issue on any cycle with stall high, at most one issue per 2 cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-high reset. Despite the name, 1 = reset asserted.
- uc_in  in  LIT_W  initial UC literal to load.
- uc_in_valid  in  1  uc_in valid.
- uc_in_ready  out  1  feeder accepts uc_in this cycle.
- start  in  1  single-cycle pulse: begin run.
- stall  in  1  engine idle / awaiting UC (from top).
- conflict  in  1  BCP conflict (from top).
- mem2uca  out  LIT_W  issued UC literal.
- mem2uca_valid  out  1  issue strobe.
- mem2uca_done  out  1  same as mem2uca_valid (UC is a single word).
- mstack_empty  in  1  model stack empty.
- mstack_lit  in  LIT_W  model stack head.
- mstack_pop  out  1  pop model stack.
- res_lit  out  LIT_W  result FIFO head.
- res_valid  out  1  result FIFO non-empty.
- res_ready  in  1  consumer pops result FIFO.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- conflict_seen  out  1  run ended by conflict.
- cycle_cnt  out  CNT_W  cycles from start to run end.
- uc_issued  out  $clog2(UC_DEPTH)+1  count of UCs issued in this run.

Behaviour:

Reset:
- Async reset clears the state to IDLE and empties both FIFOs.
- All outputs are 0 except uc_in_ready = 1.
- Reset mid-run aborts immediately; no further issue; counters are cleared.

Loading:
- uc_in_ready = (state==IDLE) & UC FIFO not full.
- uc_in is pushed when uc_in_valid & uc_in_ready.
- Loads in any other state are ignored.

FSM states and transitions:
- IDLE, start=1:
  - → RUN if UC FIFO non-empty, else → DRAIN;
  - clear cycle_cnt, uc_issued and conflict_seen.
- RUN:
  - issue condition:
    - mode 0: stall & ~stall_q;
    - mode 1: stall & ~issued_q;
  - on issue (condition met, UC FIFO non-empty, conflict=0):
    - next cycle, drive mem2uca = FIFO head with mem2uca_valid = mem2uca_done = 1 for exactly one cycle;
    - pop the FIFO;
    - increment uc_issued.
  - When the FIFO becomes empty after an issue → DRAIN.
- DRAIN: → DONE when stall=1, mstack_empty=1 and no issue is in flight, for 2 consecutive cycles.
- RUN/DRAIN, conflict=1:
  - → DONE, set conflict_seen;
  - a same-cycle issue condition is suppressed (conflict wins);
  - remaining UCs are discarded at the next start.
- DONE:
  - hold all outputs;
  - start=1 → IDLE-equivalent restart (as IDLE with start), with an empty UC FIFO → DRAIN;
  - uc_in loads are not accepted in DONE. Reset is needed to reload; alternatively, start is held off until the host flushes.

Cycle counter:
- Increments every cycle in RUN/DRAIN.
- Saturates at all-ones; no wrap.
- Frozen in DONE.

Result path:
- mstack_pop = ~mstack_empty & result FIFO not full, in any state except IDLE.
- mstack_lit is captured into the result FIFO in the same cycle as the pop.
- When the result FIFO is full, the pop is withheld (backpressure, no loss).
- Simultaneous push and pop on a full FIFO is allowed when res_ready = 1.

Result output:
- res_lit/res_valid are registered FIFO head outputs.
- The FIFO is popped on res_valid & res_ready.

Registered flags:
- stall_q and issued_q are reset to 0.
- stall already high when RUN is entered, in mode 0, does not issue until stall falls and rises again.

Test Plan:
1. Load 3 UCs (5, 9, 12); start; stall toggles with rising edges at cycles 4, 10, 20 → mem2uca = 5, 9, 12 one cycle after each rising edge; uc_issued = 3; DONE after stall high and mstack empty for 2 cycles; conflict_seen = 0.
2. Mode 0, stall held high for 8 cycles with 2 UCs loaded → exactly one issue. Mode 1, same stimulus → issues at t and t+2.
3. Conflict asserted on the same cycle as a stall rising edge, with UCs 7, 8 loaded → no mem2uca_valid; DONE; conflict_seen = 1; cycle_cnt = cycles from start.
4. mstack supplies 40 literals while res_ready = 0, RES_DEPTH = 32 → mstack_pop stops after 32; the remaining 8 are popped after res_ready goes high; output order is preserved, none lost.
5. Load UC_DEPTH + 1 literals → uc_in_ready = 0 after 16; the 17th is not accepted. Start with an empty FIFO → direct DRAIN, then DONE with uc_issued = 0.
6. rst_n pulsed mid-RUN after 1 issue → state IDLE; FIFOs empty; cycle_cnt = 0; mem2uca_valid = 0 asynchronously.

Source files
------------

// File: rtl/uc_feeder.sv
// Initial unit-clause feeder for the BCP accelerator: buffers UCs, issues them to the
// UC arbiter on engine stall, drains the model stack into a result FIFO and times the run.
module uc_feeder #(
    parameter int LIT_W      = 8,
    parameter int UC_DEPTH   = 16,
    parameter int RES_DEPTH  = 32,
    parameter int CNT_W      = 32,
    parameter int ISSUE_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LIT_W-1:0]            uc_in,
    input  logic                        uc_in_valid,
    output logic                        uc_in_ready,
    input  logic                        start,
    input  logic                        stall,
    input  logic                        conflict,
    output logic [LIT_W-1:0]            mem2uca,
    output logic                        mem2uca_valid,
    output logic                        mem2uca_done,
    input  logic                        mstack_empty,
    input  logic [LIT_W-1:0]            mstack_lit,
    output logic                        mstack_pop,
    output logic [LIT_W-1:0]            res_lit,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        conflict_seen,
    output logic [CNT_W-1:0]            cycle_cnt,
    output logic [$clog2(UC_DEPTH):0]   uc_issued
);
    localparam int UA = $clog2(UC_DEPTH);
    localparam int RA = $clog2(RES_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_n;

    logic [LIT_W-1:0] uc_mem  [UC_DEPTH];
    logic [LIT_W-1:0] res_mem [RES_DEPTH];
    logic [UA:0]      uc_wr, uc_rd;
    logic [RA:0]      res_wr, res_rd;
    logic             stall_q, issued_q, drain_ok;
    logic             uc_empty, uc_full, uc_last, uc_push;
    logic             res_empty, res_full, res_pop;
    logic             start_ok, flush, issue_cond, fire, drain_cond;

    assign uc_empty = (uc_wr == uc_rd);
    assign uc_full  = (uc_wr[UA] != uc_rd[UA]) && (uc_wr[UA-1:0] == uc_rd[UA-1:0]);
    assign uc_last  = ((uc_wr - uc_rd) == (UA+1)'(1));

    assign res_empty = (res_wr == res_rd);
    assign res_full  = (res_wr[RA] != res_rd[RA]) && (res_wr[RA-1:0] == res_rd[RA-1:0]);

    assign busy          = (state == S_RUN) || (state == S_DRAIN);
    assign done          = (state == S_DONE);
    assign uc_in_ready   = (state == S_IDLE) && !uc_full;
    assign uc_push       = uc_in_valid && uc_in_ready;
    assign start_ok      = start && ((state == S_IDLE) || (state == S_DONE));
    assign flush         = start && (state == S_DONE);

    // Mode 1 uses the issue strobe itself as the throttle, giving one issue per two cycles.
    assign issue_cond    = (ISSUE_MODE == 0) ? (stall && !stall_q) : (stall && !issued_q);
    assign fire          = (state == S_RUN) && issue_cond && !uc_empty && !conflict;
    assign drain_cond    = stall && mstack_empty && !issued_q;

    assign mem2uca_valid = issued_q;
    assign mem2uca_done  = issued_q;

    // A full result FIFO still takes a new literal when the consumer pops the same cycle.
    assign res_valid  = !res_empty;
    assign res_pop    = res_valid && res_ready;
    assign mstack_pop = (state != S_IDLE) && !mstack_empty && (!res_full || res_pop);
    assign res_lit    = res_valid ? res_mem[res_rd[RA-1:0]] : '0;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = uc_empty ? S_DRAIN : S_RUN;
            S_RUN: begin
                if (conflict)            state_n = S_DONE;
                else if (fire && uc_last) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (conflict)                    state_n = S_DONE;
                else if (drain_cond && drain_ok) state_n = S_DONE;
            end
            S_DONE:  if (start) state_n = S_DRAIN;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= S_IDLE;
            uc_wr         <= '0;
            uc_rd         <= '0;
            res_wr        <= '0;
            res_rd        <= '0;
            stall_q       <= 1'b0;
            issued_q      <= 1'b0;
            drain_ok      <= 1'b0;
            mem2uca       <= '0;
            uc_issued     <= '0;
            cycle_cnt     <= '0;
            conflict_seen <= 1'b0;
        end else begin
            state    <= state_n;
            stall_q  <= stall;
            issued_q <= fire;
            drain_ok <= (state == S_DRAIN) && drain_cond;
            if (uc_push) uc_wr <= uc_wr + 1'b1;
            if (fire) begin
                mem2uca   <= uc_mem[uc_rd[UA-1:0]];
                uc_rd     <= uc_rd + 1'b1;
                uc_issued <= uc_issued + 1'b1;
            end
            // Restarting from DONE discards whatever a conflict left behind.
            if (flush) uc_rd <= uc_wr;
            if (mstack_pop) res_wr <= res_wr + 1'b1;
            if (res_pop)    res_rd <= res_rd + 1'b1;
            if (start_ok) begin
                cycle_cnt     <= '0;
                uc_issued     <= '0;
                conflict_seen <= 1'b0;
            end else if (busy) begin
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
                if (conflict)        conflict_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (uc_push)    uc_mem[uc_wr[UA-1:0]]   <= uc_in;
        if (mstack_pop) res_mem[res_wr[RA-1:0]] <= mstack_lit;
    end
endmodule

// File: tb/tb_uc_feeder.sv
// Directed bench for uc_feeder: a mode-0 and a mode-1 instance share all inputs.
module tb_uc_feeder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] uc_in = '0;
    logic       uc_in_valid = 1'b0, start = 1'b0, stall = 1'b0, conflict = 1'b0;
    logic       mstack_empty = 1'b1, res_ready = 1'b0;
    logic [7:0] mstack_lit = '0;

    logic        a_ready, a_valid, a_done_s, a_pop, a_res_valid, a_busy, a_done, a_conf;
    logic [7:0]  a_mem, a_res;
    logic [31:0] a_cnt;
    logic [4:0]  a_issued;
    logic        b_ready, b_valid, b_done_s, b_pop, b_res_valid, b_busy, b_done, b_conf;
    logic [7:0]  b_mem, b_res;
    logic [31:0] b_cnt;
    logic [4:0]  b_issued;

    int n_checks = 0;
    int n_bad = 0;
    logic [7:0] lits [40];

    always #5 clk = ~clk;

    uc_feeder #(.ISSUE_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .uc_in(uc_in), .uc_in_valid(uc_in_valid), .uc_in_ready(a_ready),
        .start(start), .stall(stall), .conflict(conflict), .mem2uca(a_mem), .mem2uca_valid(a_valid),
        .mem2uca_done(a_done_s), .mstack_empty(mstack_empty), .mstack_lit(mstack_lit), .mstack_pop(a_pop),
        .res_lit(a_res), .res_valid(a_res_valid), .res_ready(res_ready), .busy(a_busy), .done(a_done),
        .conflict_seen(a_conf), .cycle_cnt(a_cnt), .uc_issued(a_issued)
    );

    uc_feeder #(.ISSUE_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .uc_in(uc_in), .uc_in_valid(uc_in_valid), .uc_in_ready(b_ready),
        .start(start), .stall(stall), .conflict(conflict), .mem2uca(b_mem), .mem2uca_valid(b_valid),
        .mem2uca_done(b_done_s), .mstack_empty(mstack_empty), .mstack_lit(mstack_lit), .mstack_pop(b_pop),
        .res_lit(b_res), .res_valid(b_res_valid), .res_ready(res_ready), .busy(b_busy), .done(b_done),
        .conflict_seen(b_conf), .cycle_cnt(b_cnt), .uc_issued(b_issued)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        rst_n = 1'b1;
        uc_in_valid = 1'b0; start = 1'b0; stall = 1'b0; conflict = 1'b0;
        mstack_empty = 1'b1; res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic loadUc(input logic [7:0] lit);
        uc_in = lit;
        uc_in_valid = 1'b1;
        @(negedge clk);
        uc_in_valid = 1'b0;
    endtask

    task automatic startRun();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int va, vb, idx, outn;
        logic [7:0] last_b;
        for (int i = 0; i < 40; i++) lits[i] = 8'(i * 7 + 3);

        // Reset values
        @(negedge clk);
        checkOutput("rst_ready", a_ready, 1);
        checkOutput("rst_valid", a_valid, 0);
        checkOutput("rst_busy_done", {a_busy, a_done, a_conf}, 0);
        checkOutput("rst_cnt", a_cnt, 0);
        checkOutput("rst_res_valid", a_res_valid, 0);
        rst_n = 1'b0;

        // Test 1: three UCs issued on stall rising edges at cycles 4, 10, 20
        applyReset();
        loadUc(8'd5); loadUc(8'd9); loadUc(8'd12);
        startRun();
        va = 0;
        for (int c = 1; c <= 25; c++) begin
            stall = (c == 4 || c == 5 || c == 10 || c == 11 || c >= 20);
            @(negedge clk);
            va += int'(a_valid);
            if (c == 4)  checkOutput("t1_issue0", {a_valid, a_done_s, a_mem}, {2'b11, 8'd5});
            if (c == 10) checkOutput("t1_issue1", {a_valid, a_done_s, a_mem}, {2'b11, 8'd9});
            if (c == 20) checkOutput("t1_issue2", {a_valid, a_done_s, a_mem}, {2'b11, 8'd12});
            if (c == 22) checkOutput("t1_not_done_yet", a_done, 0);
        end
        checkOutput("t1_valid_count", va, 3);
        checkOutput("t1_issued", a_issued, 3);
        checkOutput("t1_done", {a_done, a_busy}, 2'b10);
        checkOutput("t1_conflict_seen", a_conf, 0);
        checkOutput("t1_cycle_cnt", a_cnt, 23);

        // Test 2: stall held high 8 cycles, two UCs; mode 0 issues once, mode 1 at t and t+2
        applyReset();
        loadUc(8'd3); loadUc(8'd4);
        startRun();
        va = 0; vb = 0;
        for (int c = 1; c <= 14; c++) begin
            stall = (c >= 2 && c <= 9);
            @(negedge clk);
            va += int'(a_valid);
            vb += int'(b_valid);
            if (c == 2) checkOutput("t2_a_first", {a_valid, a_mem}, {1'b1, 8'd3});
            if (c == 2) checkOutput("t2_b_first", {b_valid, b_mem}, {1'b1, 8'd3});
            if (c == 3) checkOutput("t2_b_gap", b_valid, 0);
            if (c == 4) checkOutput("t2_b_second", {b_valid, b_mem}, {1'b1, 8'd4});
        end
        checkOutput("t2_a_count", va, 1);
        checkOutput("t2_b_count", vb, 2);
        checkOutput("t2_a_issued", a_issued, 1);
        checkOutput("t2_b_issued", b_issued, 2);

        // Test 3: conflict on the same cycle as a stall rising edge
        applyReset();
        loadUc(8'd7); loadUc(8'd8);
        startRun();
        va = 0;
        for (int c = 1; c <= 10; c++) begin
            stall = (c >= 3 && c != 6);
            conflict = (c == 3);
            @(negedge clk);
            va += int'(a_valid);
        end
        checkOutput("t3_no_issue", va, 0);
        checkOutput("t3_done", a_done, 1);
        checkOutput("t3_conflict_seen", a_conf, 1);
        checkOutput("t3_cycle_cnt", a_cnt, 3);
        checkOutput("t3_issued", a_issued, 0);

        // Test 4: 40 model-stack literals against a 32-deep result FIFO with backpressure
        applyReset();
        startRun();
        idx = 0;
        for (int c = 0; c < 50; c++) begin
            mstack_empty = (idx >= 40);
            mstack_lit = lits[(idx < 40) ? idx : 0];
            #1;
            if (a_pop) idx++;
            @(negedge clk);
        end
        checkOutput("t4_pops_backpressured", idx, 32);
        mstack_empty = 1'b0;
        mstack_lit = lits[idx];
        #1;
        checkOutput("t4_pop_withheld", a_pop, 0);
        @(negedge clk);
        res_ready = 1'b1;
        outn = 0;
        for (int c = 0; c < 200 && outn < 40; c++) begin
            mstack_empty = (idx >= 40);
            mstack_lit = lits[(idx < 40) ? idx : 0];
            #1;
            if (a_pop) idx++;
            if (a_res_valid) begin
                checkOutput("t4_res_order", a_res, lits[outn]);
                outn++;
            end
            @(negedge clk);
        end
        mstack_empty = 1'b1;
        res_ready = 1'b0;
        checkOutput("t4_res_count", outn, 40);
        checkOutput("t4_pops_total", idx, 40);
        checkOutput("t4_res_empty", a_res_valid, 0);

        // Test 5: UC FIFO overfill, then mode 1 drains exactly 16
        applyReset();
        for (int i = 0; i < 17; i++) begin
            checkOutput("t5_ready", a_ready, (i < 16) ? 1 : 0);
            uc_in = 8'(i + 1);
            uc_in_valid = 1'b1;
            @(negedge clk);
        end
        uc_in_valid = 1'b0;
        checkOutput("t5_full_ready", a_ready, 0);
        stall = 1'b1;
        startRun();
        vb = 0; last_b = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (b_valid) begin
                vb++;
                last_b = b_mem;
            end
        end
        checkOutput("t5_b_count", vb, 16);
        checkOutput("t5_b_last", last_b, 16);
        checkOutput("t5_b_issued", b_issued, 16);
        checkOutput("t5_b_done", b_done, 1);

        // Test 5b: start with an empty UC FIFO goes straight to DRAIN
        applyReset();
        stall = 1'b1;
        startRun();
        checkOutput("t5b_busy", {a_busy, a_done}, 2'b10);
        @(negedge clk);
        checkOutput("t5b_not_done", a_done, 0);
        @(negedge clk);
        checkOutput("t5b_done", a_done, 1);
        checkOutput("t5b_issued", a_issued, 0);
        checkOutput("t5b_cycle_cnt", a_cnt, 2);

        // Test 6: asynchronous reset mid-run right after an issue
        applyReset();
        loadUc(8'd10); loadUc(8'd11); loadUc(8'd12);
        startRun();
        stall = 1'b1;
        @(negedge clk);
        checkOutput("t6_issue", {a_valid, a_mem}, {1'b1, 8'd10});
        #1 rst_n = 1'b1;
        #1;
        checkOutput("t6_async_valid", a_valid, 0);
        checkOutput("t6_async_state", {a_busy, a_done, a_ready}, 3'b001);
        checkOutput("t6_async_cnt", a_cnt, 0);
        checkOutput("t6_async_issued", a_issued, 0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        startRun();
        va = 0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            va += int'(a_valid);
        end
        checkOutput("t6_fifo_empty_done", a_done, 1);
        checkOutput("t6_no_issue", va, 0);
        checkOutput("t6_issued", a_issued, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
